// File: rtl/cordic_pkg.sv
// Shared defaults and state encoding for the cordic request scheduler.
package cordic_pkg;

  localparam int THETA_W_DEFAULT  = 23;
  localparam int RESULT_W_DEFAULT = 22;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester after last_grant wins,
// wrapping modulo N.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last_grant,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] cand_idx [N];
  logic [N-1:0]  cand_req;

  // Candidate gi is the requester gi+1 places after the previous winner.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cand
      logic [IW:0] sum;
      assign sum           = {1'b0, last_grant} + (IW+1)'(gi + 1);
      assign cand_idx[gi]  = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : IW'(sum);
      assign cand_req[gi]  = req[cand_idx[gi]];
    end
  endgenerate

  always_comb begin
    grant_idx = '0;
    grant     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (cand_req[k]) begin
        grant_idx = cand_idx[k];
      end
    end
    if (|req) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/cordic_scheduler.sv
// Shares one iterative cordic core between N_REQ requesters: round-robin accept,
// start/done sequencing with timeout abort, and a held per-requester response.
module cordic_scheduler
  import cordic_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int THETA_W  = THETA_W_DEFAULT,
  parameter int RESULT_W = RESULT_W_DEFAULT,
  parameter int TIMEOUT  = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clk_en,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*THETA_W-1:0]   req_theta,
  output logic [N_REQ-1:0]           rsp_valid,
  input  logic [N_REQ-1:0]           rsp_ready,
  output logic [RESULT_W-1:0]        rsp_result,
  output logic                       rsp_err,
  output logic                       busy,
  output logic                       core_clk_en,
  output logic                       core_start,
  output logic [THETA_W-1:0]         core_theta,
  input  logic                       core_done,
  input  logic [RESULT_W-1:0]        core_result
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);
  // Abort on the cycle the counter would reach TIMEOUT-1, so the error
  // response lands TIMEOUT cycles after core_start.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 2);

  sched_state_t         state_reg;
  logic [IDX_W-1:0]     last_grant_reg;
  logic [IDX_W-1:0]     id_reg;
  logic [THETA_W-1:0]   theta_reg;
  logic [CNT_W-1:0]     count_reg;
  logic [RESULT_W-1:0]  result_reg;
  logic                 err_reg;
  logic                 start_reg;
  logic [N_REQ-1:0]     rsp_valid_reg;
  logic                 busy_reg;

  logic [N_REQ-1:0]     grant;
  logic [IDX_W-1:0]     grant_idx;
  logic [THETA_W-1:0]   grant_theta;
  logic [N_REQ-1:0]     id_onehot;
  logic                 accept_ok;

  rr_arbiter #(
    .N (N_REQ)
  ) u_arbiter (
    .req        (req_valid),
    .last_grant (last_grant_reg),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  assign grant_theta = req_theta[grant_idx*THETA_W +: THETA_W];
  assign id_onehot   = N_REQ'(1) << id_reg;
  assign accept_ok   = (state_reg == IDLE) && clk_en && reset;

  assign req_ready   = accept_ok ? grant : '0;
  assign rsp_valid   = rsp_valid_reg;
  assign rsp_result  = result_reg;
  assign rsp_err     = err_reg;
  assign busy        = busy_reg;
  assign core_clk_en = clk_en;
  assign core_start  = start_reg;
  assign core_theta  = theta_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= IDX_W'(N_REQ - 1);
      id_reg         <= '0;
      theta_reg      <= '0;
      count_reg      <= '0;
      result_reg     <= '0;
      err_reg        <= 1'b0;
      start_reg      <= 1'b0;
      rsp_valid_reg  <= '0;
      busy_reg       <= 1'b0;
    end else if (clk_en) begin
      case (state_reg)
        IDLE: begin
          if (|grant) begin
            theta_reg      <= grant_theta;
            id_reg         <= grant_idx;
            last_grant_reg <= grant_idx;
            start_reg      <= 1'b1;
            busy_reg       <= 1'b1;
            state_reg      <= ISSUE;
          end
        end
        ISSUE: begin
          start_reg <= 1'b0;
          count_reg <= '0;
          state_reg <= BUSY;
        end
        BUSY: begin
          count_reg <= count_reg + CNT_W'(1);
          // A done arriving on the timeout cycle still delivers its result.
          if (core_done) begin
            result_reg    <= core_result;
            err_reg       <= 1'b0;
            rsp_valid_reg <= id_onehot;
            state_reg     <= RESP;
          end else if (count_reg == LAST_CNT) begin
            result_reg    <= '0;
            err_reg       <= 1'b1;
            rsp_valid_reg <= id_onehot;
            state_reg     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready[id_reg]) begin
            rsp_valid_reg <= '0;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_scheduler.sv
// Directed bench for cordic_scheduler with a fixed-latency behavioural core.
`timescale 1ns/1ps
module tb_cordic_scheduler;

  localparam int N_REQ    = 4;
  localparam int THETA_W  = 23;
  localparam int RESULT_W = 22;
  localparam int TIMEOUT  = 64;
  localparam int LAT      = 3;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic                     clk_en = 1'b1;
  logic [N_REQ-1:0]         req_valid = '0;
  logic [N_REQ-1:0]         req_ready;
  logic [N_REQ*THETA_W-1:0] req_theta;
  logic [N_REQ-1:0]         rsp_valid;
  logic [N_REQ-1:0]         rsp_ready = '0;
  logic [RESULT_W-1:0]      rsp_result;
  logic                     rsp_err;
  logic                     busy;
  logic                     core_clk_en;
  logic                     core_start;
  logic [THETA_W-1:0]       core_theta;
  logic                     core_done;
  logic [RESULT_W-1:0]      core_result;

  logic [THETA_W-1:0]  theta_arr [N_REQ];
  logic [RESULT_W-1:0] exp_res   [N_REQ];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    req_theta = '0;
    for (int i = 0; i < N_REQ; i++) req_theta[i*THETA_W +: THETA_W] = theta_arr[i];
  end

  cordic_scheduler #(
    .N_REQ(N_REQ), .THETA_W(THETA_W), .RESULT_W(RESULT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en),
    .req_valid(req_valid), .req_ready(req_ready), .req_theta(req_theta),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_err(rsp_err), .busy(busy), .core_clk_en(core_clk_en),
    .core_start(core_start), .core_theta(core_theta),
    .core_done(core_done), .core_result(core_result)
  );

  // Behavioural core: done pulses LAT enabled cycles after the start edge.
  logic               m_active = 1'b0;
  int                 m_cnt = 0;
  logic [THETA_W-1:0] m_theta = '0;
  logic               never_done = 1'b0;
  logic               inject_done = 1'b0;
  logic               model_done;

  function automatic logic [RESULT_W-1:0] core_fn(input logic [THETA_W-1:0] t);
    if (t == 23'h200000) return 22'h0229F1;
    return t[RESULT_W-1:0] ^ 22'h0F0F0F;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      m_active <= 1'b0;
      m_cnt    <= 0;
      m_theta  <= '0;
    end else if (core_clk_en) begin
      if (core_start) begin
        m_active <= 1'b1;
        m_cnt    <= LAT - 1;
        m_theta  <= core_theta;
      end else if (m_active) begin
        if (m_cnt == 0) m_active <= 1'b0;
        else m_cnt <= m_cnt - 1;
      end
    end
  end

  assign model_done  = m_active && (m_cnt == 0) && !never_done;
  assign core_done   = model_done || inject_done;
  assign core_result = model_done ? core_fn(m_theta) : 22'h2A5A5A;

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, rsp_valid, rsp_err, core_start} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: busy=%b rsp_valid=%b rsp_err=%b core_start=%b expected all 0",
               busy, rsp_valid, rsp_err, core_start);
    end
    vectors++;
    if (rsp_result !== 22'h0 || core_theta !== 23'h0) begin
      miscompares++;
      $display("FAIL reset_data: rsp_result=%h core_theta=%h expected 0", rsp_result, core_theta);
    end
    clk_en = 1'b0;
    #1;
    vectors++;
    if (core_clk_en !== 1'b0) begin
      miscompares++;
      $display("FAIL core_clk_en: got %b expected 0", core_clk_en);
    end
    clk_en = 1'b1;
    reset  = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    req_valid = 4'b0001;
    #1;
    vectors++;
    if (req_ready !== 4'b0001) begin
      miscompares++;
      $display("FAIL single_ready: req_ready=%b expected 0001", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    vectors++;
    if (core_start !== 1'b1 || core_theta !== 23'h200000) begin
      miscompares++;
      $display("FAIL single_start: core_start=%b core_theta=%h expected 1/200000", core_start, core_theta);
    end
    @(negedge clk);
    vectors++;
    if (core_start !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL single_pulse: core_start=%b busy=%b expected 0/1", core_start, busy);
    end
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 4'b0000) begin
        miscompares++;
        $display("FAIL single_early: rsp_valid=%b expected 0000", rsp_valid);
      end
    end
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 4'b0001 || rsp_result !== 22'h0229F1 || rsp_err !== 1'b0) begin
      miscompares++;
      $display("FAIL single_rsp: rsp_valid=%b result=%h err=%b expected 0001/0229f1/0",
               rsp_valid, rsp_result, rsp_err);
    end
    rsp_ready = 4'b0001;
    @(negedge clk);
    rsp_ready = '0;
    vectors++;
    if (busy !== 1'b0 || rsp_valid !== 4'b0000) begin
      miscompares++;
      $display("FAIL single_idle: busy=%b rsp_valid=%b expected 0/0000", busy, rsp_valid);
    end
  endtask

  task automatic test_fairness();
    int k;
    int prev_acc;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    req_valid = 4'hF;
    rsp_ready = 4'hF;
    prev_acc  = 0;
    for (int i = 0; i < 8; i++) begin
      k = 0;
      #1;
      while (req_ready == '0 && k < 50) begin
        @(negedge clk);
        k++;
      end
      vectors++;
      if (req_ready !== (4'b0001 << (i % 4))) begin
        miscompares++;
        $display("FAIL fair_grant[%0d]: req_ready=%b expected %b", i, req_ready, 4'b0001 << (i % 4));
      end
      if (i > 0) begin
        vectors++;
        if (cyc - prev_acc != LAT + 3) begin
          miscompares++;
          $display("FAIL fair_spacing[%0d]: %0d cycles expected %0d", i, cyc - prev_acc, LAT + 3);
        end
      end
      prev_acc = cyc;
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (rsp_valid == '0 && k < 20);
      if (i == 7) req_valid = '0;
      vectors++;
      if (rsp_valid !== (4'b0001 << (i % 4)) || rsp_result !== exp_res[i % 4] || rsp_err !== 1'b0) begin
        miscompares++;
        $display("FAIL fair_rsp[%0d]: rsp_valid=%b result=%h err=%b expected %b/%h/0",
                 i, rsp_valid, rsp_result, rsp_err, 4'b0001 << (i % 4), exp_res[i % 4]);
      end
    end
    @(negedge clk);
    rsp_ready = '0;
  endtask

  task automatic test_back_to_back_backpressure();
    int k;
    req_valid = 4'b1000;
    #1;
    vectors++;
    if (req_ready !== 4'b1000) begin
      miscompares++;
      $display("FAIL bp_grant: req_ready=%b expected 1000", req_ready);
    end
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) req_valid = 4'b0111;
    end while (rsp_valid == '0 && k < 20);
    rsp_ready = 4'b0111;
    for (int j = 0; j < 10; j++) begin
      vectors++;
      if (rsp_valid !== 4'b1000 || rsp_result !== exp_res[3] || req_ready !== 4'b0000) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: rsp_valid=%b result=%h req_ready=%b expected 1000/%h/0000",
                 j, rsp_valid, rsp_result, req_ready, exp_res[3]);
      end
      @(negedge clk);
    end
    rsp_ready = 4'b1000;
    @(negedge clk);
    rsp_ready = '0;
    vectors++;
    if (rsp_valid !== 4'b0000 || req_ready !== 4'b0001) begin
      miscompares++;
      $display("FAIL bp_release: rsp_valid=%b req_ready=%b expected 0000/0001", rsp_valid, req_ready);
    end
    req_valid = '0;
  endtask

  task automatic test_timeout();
    int k;
    never_done = 1'b1;
    req_valid  = 4'b0010;
    #1;
    vectors++;
    if (req_ready !== 4'b0010) begin
      miscompares++;
      $display("FAIL to_grant: req_ready=%b expected 0010", req_ready);
    end
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) req_valid = '0;
    end while (rsp_valid == '0 && k < 100);
    vectors++;
    if (k != TIMEOUT + 1) begin
      miscompares++;
      $display("FAIL to_latency: response after %0d cycles expected %0d", k, TIMEOUT + 1);
    end
    vectors++;
    if (rsp_valid !== 4'b0010 || rsp_err !== 1'b1 || rsp_result !== 22'h0) begin
      miscompares++;
      $display("FAIL to_rsp: rsp_valid=%b err=%b result=%h expected 0010/1/0", rsp_valid, rsp_err, rsp_result);
    end
    repeat (5) @(negedge clk);
    inject_done = 1'b1;
    @(negedge clk);
    inject_done = 1'b0;
    vectors++;
    if (rsp_valid !== 4'b0010 || rsp_err !== 1'b1 || rsp_result !== 22'h0) begin
      miscompares++;
      $display("FAIL to_late_done: rsp_valid=%b err=%b result=%h expected 0010/1/0", rsp_valid, rsp_err, rsp_result);
    end
    rsp_ready = 4'b0010;
    @(negedge clk);
    rsp_ready   = '0;
    inject_done = 1'b1;
    @(negedge clk);
    inject_done = 1'b0;
    never_done  = 1'b0;
    vectors++;
    if (busy !== 1'b0 || rsp_valid !== 4'b0000) begin
      miscompares++;
      $display("FAIL to_idle_done: busy=%b rsp_valid=%b expected 0/0000", busy, rsp_valid);
    end
  endtask

  task automatic test_clk_en();
    clk_en    = 1'b0;
    req_valid = 4'b0100;
    #1;
    vectors++;
    if (req_ready !== 4'b0000) begin
      miscompares++;
      $display("FAIL ce_gate: req_ready=%b expected 0000", req_ready);
    end
    clk_en = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 4'b0100) begin
      miscompares++;
      $display("FAIL ce_grant: req_ready=%b expected 0100", req_ready);
    end
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = '0;
      if (k <= 3) begin
        vectors++;
        if (core_start !== 1'b1) begin
          miscompares++;
          $display("FAIL ce_issue_hold[%0d]: core_start=%b expected 1", k, core_start);
        end
      end else if (k <= 9) begin
        vectors++;
        if (core_start !== 1'b0 || req_ready !== 4'b0000 || busy !== 1'b1) begin
          miscompares++;
          $display("FAIL ce_busy_hold[%0d]: core_start=%b req_ready=%b busy=%b expected 0/0000/1",
                   k, core_start, req_ready, busy);
        end
      end else if (k <= 12) begin
        vectors++;
        if (rsp_valid !== 4'b0000) begin
          miscompares++;
          $display("FAIL ce_early[%0d]: rsp_valid=%b expected 0000", k, rsp_valid);
        end
      end else begin
        vectors++;
        if (rsp_valid !== 4'b0100 || rsp_result !== exp_res[2] || rsp_err !== 1'b0) begin
          miscompares++;
          $display("FAIL ce_rsp: rsp_valid=%b result=%h err=%b expected 0100/%h/0",
                   rsp_valid, rsp_result, rsp_err, exp_res[2]);
        end
      end
      if (k == 1 || k == 4) clk_en = 1'b0;
      if (k == 3 || k == 10) clk_en = 1'b1;
      if (k == 4) req_valid = 4'b0001;
      if (k == 13) req_valid = '0;
    end
    rsp_ready = 4'b0100;
    @(negedge clk);
    rsp_ready = '0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL ce_idle: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    req_valid = 4'b0010;
    #1;
    vectors++;
    if (req_ready !== 4'b0010) begin
      miscompares++;
      $display("FAIL rm_grant: req_ready=%b expected 0010", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    vectors++;
    if ({busy, rsp_valid, rsp_err, core_start} !== 7'b0 || rsp_result !== 22'h0 || core_theta !== 23'h0) begin
      miscompares++;
      $display("FAIL rm_outputs: busy=%b rsp_valid=%b err=%b start=%b result=%h theta=%h expected all 0",
               busy, rsp_valid, rsp_err, core_start, rsp_result, core_theta);
    end
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid != '0 || busy != 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL rm_no_rsp: %0d cycles with activity expected 0", bad);
    end
    req_valid = 4'b0101;
    rsp_ready = 4'b0001;
    #1;
    vectors++;
    if (req_ready !== 4'b0001) begin
      miscompares++;
      $display("FAIL rm_first: req_ready=%b expected 0001", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0100;
    repeat (LAT + 2) @(negedge clk);
    #1;
    vectors++;
    if (req_ready !== 4'b0100) begin
      miscompares++;
      $display("FAIL rm_second: req_ready=%b expected 0100", req_ready);
    end
    req_valid = '0;
    rsp_ready = '0;
    @(negedge clk);
  endtask

  initial begin
    theta_arr[0] = 23'h200000;  exp_res[0] = 22'h0229F1;
    theta_arr[1] = 23'h012345;  exp_res[1] = 22'h0E2C4A;
    theta_arr[2] = 23'h5A5A5A;  exp_res[2] = 22'h155555;
    theta_arr[3] = 23'h7FFFFF;  exp_res[3] = 22'h30F0F0;
    @(negedge clk);
    test_reset();
    test_single();
    test_fairness();
    test_back_to_back_backpressure();
    test_timeout();
    test_clk_en();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule

// File: doc/cordic_scheduler.md
# cordic_scheduler

Round-robin scheduler that shares one iterative `cordic` core between `N_REQ` requesters. It accepts one angle at a time over a valid/ready handshake and sequences the core's `start`/`done` protocol. It returns the result to the originating requester over a held response handshake, and aborts with an error if the core does not answer within a timeout. It sits between the requester ports (custom-instruction / DMA front ends) and the single `cordic` instance.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..8).
- `THETA_W`, 23: angle width, fixed-point, same format as `cordic.fixedPoint_theta`.
- `RESULT_W`, 22: result width, same format as `cordic.fixedPoint_result`.
- `TIMEOUT`, 64: maximum cycles from `core_start` to `core_done` before abort (≥ 2).

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-low reset.
- `clk_en`  in  1  global clock enable; when low, all state holds.
- `req_valid`  in  N_REQ  per-requester request valid.
- `req_ready`  out  N_REQ  per-requester accept, one-hot or zero.
- `req_theta`  in  N_REQ*THETA_W  packed angles; requester i occupies bits [i*THETA_W +: THETA_W].
- `rsp_valid`  out  N_REQ  one-hot response valid for the owning requester.
- `rsp_ready`  in  N_REQ  per-requester response accept.
- `rsp_result`  out  RESULT_W  result, shared by all requesters.
- `rsp_err`  out  1  response is a timeout abort; `rsp_result` = 0.
- `busy`  out  1  state ≠ IDLE.
- `core_clk_en`  out  1  equals `clk_en`.
- `core_start`  out  1  one-cycle start pulse to the core.
- `core_theta`  out  THETA_W  angle to the core, held from ISSUE until the next accept.
- `core_done`  in  1  core completion pulse.
- `core_result`  in  RESULT_W  core result, valid when `core_done` = 1.

## Operation
- FSM states: IDLE, ISSUE, BUSY, RESP.
- IDLE:
  - The grant is the first requester with `req_valid` set, searching from `last_grant+1` and wrapping modulo N_REQ.
  - `req_ready[g]` = 1 combinationally for the granted requester only, and only while `clk_en` is high.
  - On handshake: latch `theta`, `id`=g, `last_grant`=g; go to ISSUE.
- ISSUE: `core_start`=1 for exactly one cycle; clear the timeout counter; go to BUSY.
- BUSY: the counter increments each enabled cycle.
  - If `core_done`=1: latch `core_result`, `rsp_err`=0; go to RESP.
  - Otherwise, if counter = TIMEOUT-1: `rsp_result`=0, `rsp_err`=1; go to RESP.
  - If `core_done` arrives in the same cycle as the timeout, `core_done` wins.
- RESP:
  - `rsp_valid[id]`=1, with `rsp_result` and `rsp_err` stable until `rsp_ready[id]`=1.
  - `rsp_ready` bits of other requesters are ignored.
  - After the handshake, go to IDLE.
- `core_done` outside BUSY is ignored, including a late `done` after a timeout.
- `clk_en`=0 freezes the FSM, counter, latches and `last_grant`. Outputs hold, `req_ready`=0 and `core_start` is not re-pulsed. `core_start` stays asserted only if frozen while in ISSUE.
- Reset (`reset`=0 at a clock edge):
  - Overrides `clk_en`.
  - Outputs return to reset values: state IDLE, `last_grant`=N_REQ-1 (requester 0 wins first), `rsp_valid`=0, `rsp_err`=0, `rsp_result`=0, `core_start`=0, `core_theta`=0, `busy`=0, counter 0.
  - Reset mid-operation drops the in-flight request with no response. The core is reset by the same system reset outside this block.

## Timing
- Accept at edge T; `core_start` high during cycle T+1.
- Core latency L (done pulses in cycle T+1+L): `rsp_valid` is high from cycle T+2+L.
- Response handshake at edge R: IDLE in cycle R+1, and the next accept is possible at edge R+1.
- Throughput is one request per L+3 cycles with immediate `rsp_ready`.
- Timeout with no `done`: `rsp_valid` with `rsp_err`=1 in cycle T+1+TIMEOUT.
- At most one request is in flight; no queuing.

## Structure
- `cordic_pkg`: `THETA_W`, `RESULT_W` defaults and the `sched_state_t` enum (IDLE, ISSUE, BUSY, RESP).
- Sub-module `rr_arbiter`: parameter N; inputs `req`, `last_grant`; outputs one-hot `grant` and `grant_idx`. It is purely combinational.
- The counter width is `$clog2(TIMEOUT)`.

## Test plan
Use a behavioural core model with L=3 unless stated.
- Single request: requester 0, theta 23'h200000, model returns 22'h0229F1. Accept at T, `core_start` in cycle T+1, `rsp_valid`=4'b0001 in cycle T+5 with `rsp_result`=22'h0229F1 and `rsp_err`=0.
- Fairness: all four `req_valid` held high for 8 requests. Grant order is 0,1,2,3,0,1,2,3, with no requester served twice while another waits.
- Response backpressure: `rsp_ready` held low for 10 cycles. `rsp_valid`/`rsp_result` stay stable, and no `req_ready` is asserted until the handshake.
- Timeout: model never asserts `done`, TIMEOUT=64. Response arrives in cycle T+65 with `rsp_err`=1 and `rsp_result`=0. A `done` injected 5 cycles later is ignored.
- `clk_en` low for 6 cycles during BUSY: L is stretched by 6, the counter does not advance, and the result is still correct.
- Reset asserted in BUSY:
  - Next cycle: IDLE, `busy`=0, all outputs at reset values, no response.
  - A subsequent request from requester 2, with 0 and 2 both valid, grants requester 0 first.
